// File: rtl/demux_ctrl.sv
// demux_ctrl: feeds a serial bit stream into a 1:4 demux, one burst per lane.
// Lanes are granted round-robin among the enabled ones; each grant carries a
// burst of inBurstLen accepted beats. A stop request is deferred to the end
// of the burst in progress, so a burst is never cut short except by reset.
module demux_ctrl #(
    parameter int BURST_W = 4
) (
    input  logic               inClk,
    input  logic               inResetN,
    input  logic               inStart,
    input  logic               inStop,
    input  logic [3:0]         inLaneEn,
    input  logic [BURST_W-1:0] inBurstLen,
    input  logic               inData,
    input  logic               inValid,
    output logic               outReady,
    input  logic [3:0]         inLaneReady,
    output logic [1:0]         outSel,
    output logic               outDemuxData,
    output logic [3:0]         outLaneValid,
    output logic               outBusy,
    output logic [15:0]        outBitCnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    localparam logic [BURST_W-1:0] LP_ONE = BURST_W'(1);

    state_t             r_state;
    logic [1:0]         r_lastLane;
    logic [1:0]         r_sel;
    logic [BURST_W-1:0] r_burstCnt;
    logic               r_stop;
    logic [1:0]         r_outSel;
    logic               r_data;
    logic [3:0]         r_laneValid;
    logic [15:0]        r_bitCnt;

    logic               w_ready;
    logic               w_accept;
    logic               w_lastBeat;
    logic               w_stopAny;
    logic [1:0]         w_grant;
    logic [BURST_W-1:0] w_len;

    // Round-robin pick: first enabled lane after 'last', wrapping 3->0.
    // 'last' itself is considered only after the other three lanes.
    function automatic logic [1:0] f_next_lane(input logic [1:0] last,
                                               input logic [3:0] en);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (en[idx]) pick = idx;
        end
        return pick;
    endfunction

    // Source handshake and burst bookkeeping terms.
    always_comb begin
        w_ready    = (r_state == S_XFER) && inLaneReady[r_sel];
        w_accept   = w_ready && inValid;
        w_lastBeat = (r_burstCnt == LP_ONE);
        w_stopAny  = r_stop || inStop;
        w_grant    = f_next_lane(r_lastLane, inLaneEn);
        w_len      = (inBurstLen == '0) ? LP_ONE : inBurstLen;
    end

    // Control FSM: lane arbitration, burst counting and deferred stop.
    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) begin
            r_state    <= S_IDLE;
            r_lastLane <= 2'd3;
            r_sel      <= 2'd0;
            r_burstCnt <= '0;
            r_stop     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A stop in IDLE has nothing to defer; start+stop cancels.
                    if (inStart && !inStop) r_state <= S_ARB;
                end
                S_ARB: begin
                    if (r_stop || (inLaneEn == 4'd0)) begin
                        r_state <= S_IDLE;
                        r_stop  <= 1'b0;
                    end else begin
                        r_sel      <= w_grant;
                        r_lastLane <= w_grant;
                        r_burstCnt <= w_len;
                        // Old request cleared; a pulse arriving now still counts.
                        r_stop     <= inStop;
                        r_state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    r_stop <= w_stopAny;
                    if (w_accept) begin
                        r_burstCnt <= r_burstCnt - LP_ONE;
                        if (w_lastBeat) begin
                            if (w_stopAny) begin
                                r_state <= S_IDLE;
                                r_stop  <= 1'b0;
                            end else begin
                                r_state <= S_ARB;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stop  <= 1'b0;
                end
            endcase
        end
    end

    // Output datapath: registered bit, select and one-cycle lane strobe.
    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) begin
            r_outSel    <= 2'd0;
            r_data      <= 1'b0;
            r_laneValid <= 4'd0;
            r_bitCnt    <= 16'd0;
        end else begin
            r_laneValid <= 4'd0;
            if (w_accept) begin
                r_outSel    <= r_sel;
                r_data      <= inData;
                r_laneValid <= 4'b0001 << r_sel;
                r_bitCnt    <= r_bitCnt + 16'd1;
            end
        end
    end

    assign outReady     = w_ready;
    assign outSel       = r_outSel;
    assign outDemuxData = r_data;
    assign outLaneValid = r_laneValid;
    assign outBusy      = (r_state != S_IDLE);
    assign outBitCnt    = r_bitCnt;

endmodule

// File: tb/tb_demux_ctrl.sv
// Scoreboard bench for demux_ctrl: a driver advances a behavioural model each
// cycle and queues every expected delivery; a monitor checks each strobe.
module tb_demux_ctrl;

    logic        inClk = 1'b0;
    logic        inResetN;
    logic        inStart, inStop, inData, inValid;
    logic [3:0]  inLaneEn, inLaneReady;
    logic [3:0]  inBurstLen;
    logic        outReady, outDemuxData, outBusy;
    logic [1:0]  outSel;
    logic [3:0]  outLaneValid;
    logic [15:0] outBitCnt;

    demux_ctrl #(.BURST_W(4)) dut (
        .inClk(inClk), .inResetN(inResetN), .inStart(inStart), .inStop(inStop),
        .inLaneEn(inLaneEn), .inBurstLen(inBurstLen), .inData(inData),
        .inValid(inValid), .outReady(outReady), .inLaneReady(inLaneReady),
        .outSel(outSel), .outDemuxData(outDemuxData), .outLaneValid(outLaneValid),
        .outBusy(outBusy), .outBitCnt(outBitCnt)
    );

    always #5 inClk = ~inClk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // stimulus
    logic       s_rst = 0, s_start = 0, s_stop = 0, s_valid = 0;
    logic [3:0] s_en = 4'hF, s_lrdy = 4'hF, s_len = 4'd2;

    // behavioural model: phase 0 = idle, 1 = choosing a lane, 2 = moving bits
    int          m_phase = 0;
    int          m_last  = 3;
    int          m_lane  = 0;
    int          m_left  = 0;
    bit          m_stopReq = 0;
    logic [15:0] m_cnt = 0;
    logic [1:0]  m_outSel = 0;
    logic [2:0]  sb[$];       // {lane, data} per expected delivery
    int          got_lanes[$];

    task automatic model_reset();
        m_phase = 0; m_last = 3; m_lane = 0; m_left = 0; m_stopReq = 0;
        m_cnt = 0; m_outSel = 0; sb.delete();
    endtask

    task automatic step();
        bit exp_ready;
        if (!s_rst) begin
            model_reset();
            chk("ready_in_reset", outReady, 0);
            return;
        end
        exp_ready = (m_phase == 2) && s_lrdy[m_lane];
        chk("outReady", outReady, exp_ready);
        if (m_phase == 0) begin
            if (s_start && !s_stop) m_phase = 1;
        end else if (m_phase == 1) begin
            if (m_stopReq || s_en == 0) begin
                m_phase = 0; m_stopReq = 0;
            end else begin
                for (int k = 1; k <= 4; k++)
                    if (s_en[(m_last + k) % 4]) begin m_lane = (m_last + k) % 4; break; end
                m_last = m_lane;
                m_left = (s_len == 0) ? 1 : int'(s_len);
                m_stopReq = s_stop;
                m_phase = 2;
            end
        end else begin
            m_stopReq = m_stopReq | s_stop;
            if (s_valid && exp_ready) begin
                sb.push_back({m_lane[1:0], inData});
                m_cnt++;
                m_outSel = m_lane[1:0];
                m_left--;
                if (m_left == 0) begin
                    if (m_stopReq) begin m_phase = 0; m_stopReq = 0; end
                    else m_phase = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge inClk);
        inResetN = s_rst; inStart = s_start; inStop = s_stop; inValid = s_valid;
        inLaneEn = s_en; inLaneReady = s_lrdy; inBurstLen = s_len;
        inData = 1'($urandom_range(0, 1));
        #1;
        step();
    endtask

    task automatic pulse_start();
        s_start = 1; tick(); s_start = 0;
    endtask

    task automatic wait_cnt(input logic [15:0] target);
        int n = 0;
        while (m_cnt != target && n < 200) begin tick(); n++; end
        chk("wait_cnt_timeout", m_cnt, target);
    endtask

    task automatic run_until_idle();
        int n = 0;
        while (m_phase != 0 && n < 200) begin tick(); n++; end
        chk("idle_timeout", m_phase, 0);
    endtask

    // Monitor: every strobe must match the oldest queued delivery, one cycle on.
    initial begin
        logic [2:0] e;
        forever begin
            @(posedge inClk); #1;
            if (outLaneValid != 4'd0) begin
                for (int i = 0; i < 4; i++) if (outLaneValid[i]) got_lanes.push_back(i);
                if (sb.size() == 0) chk("unexpected_strobe", outLaneValid, 0);
                else begin
                    e = sb.pop_front();
                    chk("lane_strobe", outLaneValid, 4'b0001 << e[2:1]);
                    chk("demux_data", outDemuxData, e[0]);
                end
            end else if (sb.size() != 0) begin
                chk("missing_strobe", outLaneValid, 4'b0001 << sb[0][2:1]);
                void'(sb.pop_front());
            end
            chk("outSel", outSel, m_outSel);
            chk("outBusy", outBusy, m_phase != 0);
            chk("outBitCnt", outBitCnt, m_cnt);
        end
    end

    initial begin
        logic [15:0] base;
        inResetN = 0; inStart = 0; inStop = 0; inData = 0; inValid = 0;
        inLaneEn = 0; inLaneReady = 0; inBurstLen = 0;
        repeat (3) tick();
        chk("rst_sel", outSel, 0);
        chk("rst_lv", outLaneValid, 0);
        chk("rst_busy", outBusy, 0);
        chk("rst_cnt", outBitCnt, 0);
        chk("rst_data", outDemuxData, 0);
        s_rst = 1; tick();

        // all lanes, burst 2: lanes 0,0,1,1,2,2,3,3
        s_en = 4'hF; s_len = 2; s_valid = 1; s_lrdy = 4'hF;
        got_lanes.delete();
        pulse_start();
        wait_cnt(8);
        tick();
        chk("s1_bitcnt", outBitCnt, 16'd8);
        for (int i = 0; i < 8; i++)
            chk("s1_lane_order", (got_lanes.size() > i) ? got_lanes[i] : -1, i / 2);
        s_stop = 1; tick(); s_stop = 0;
        run_until_idle(); tick();

        // lanes 1 and 3 only, burst 1
        s_en = 4'b1010; s_len = 1; got_lanes.delete(); base = m_cnt;
        pulse_start();
        wait_cnt(base + 4);
        tick();
        for (int i = 0; i < 4; i++)
            chk("s2_lane_order", (got_lanes.size() > i) ? got_lanes[i] : -1, (i % 2 == 0) ? 1 : 3);
        s_stop = 1; tick(); s_stop = 0;
        run_until_idle(); tick();

        // lane 0 stalls for 5 cycles mid-burst; stop requested during the stall
        s_en = 4'b0001; s_len = 4; base = m_cnt;
        pulse_start();
        wait_cnt(base + 2);
        s_lrdy = 4'b1110;
        for (int i = 0; i < 5; i++) begin
            s_stop = (i == 2); tick();
            chk("s3_stall_ready", outReady, 0);
        end
        s_stop = 0; s_lrdy = 4'hF;
        run_until_idle(); tick();
        chk("s3_total_bits", outBitCnt, base + 4);

        // stop after the first bit of a 3-bit burst
        s_en = 4'hF; s_len = 3; base = m_cnt;
        pulse_start();
        wait_cnt(base + 1);
        s_stop = 1; tick(); s_stop = 0;
        run_until_idle(); tick();
        chk("s4_bits", outBitCnt, base + 3);
        chk("s4_idle", outBusy, 0);
        s_start = 1; s_stop = 1; tick(); s_start = 0; s_stop = 0; tick();
        chk("s4_start_stop", outBusy, 0);

        // no lanes enabled: ARB then back to IDLE
        s_en = 4'd0;
        pulse_start();
        tick();
        chk("s5_arb_busy", outBusy, 1);
        tick();
        chk("s5_idle", outBusy, 0);
        tick();

        // reset mid-burst, then first grant goes to lane 0
        s_en = 4'hF; s_len = 8; base = m_cnt;
        pulse_start();
        wait_cnt(base + 3);
        s_rst = 0; tick();
        chk("s6_rst_lv", outLaneValid, 0);
        chk("s6_rst_busy", outBusy, 0);
        chk("s6_rst_cnt", outBitCnt, 0);
        chk("s6_rst_sel", outSel, 0);
        chk("s6_rst_ready", outReady, 0);
        tick(); tick();
        s_rst = 1; tick(); tick();
        chk("s6_stays_idle", outBusy, 0);
        got_lanes.delete();
        pulse_start();
        wait_cnt(16'd1);
        tick();
        chk("s6_first_lane", (got_lanes.size() > 0) ? got_lanes[0] : -1, 0);
        s_stop = 1; tick(); s_stop = 0;
        run_until_idle(); tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            s_en    = 4'($urandom_range(0, 15));
            s_len   = 4'($urandom_range(0, 15));
            s_valid = ($urandom_range(0, 3) != 0);
            s_lrdy  = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            s_start = ($urandom_range(0, 7) == 0);
            s_stop  = ($urandom_range(0, 23) == 0);
            tick();
        end
        s_start = 0; s_stop = 1; s_valid = 1; s_lrdy = 4'hF; tick(); s_stop = 0;
        run_until_idle();
        tick(); tick();
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/demux_ctrl.md
DEMUX_CTRL -- requirements
Module: demux_ctrl

Interface
REQ-001 The block SHALL have parameter BURST_W, default 4, meaning the width of the per-lane burst length field.
REQ-002 Port inClk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port inResetN SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-004 Port inStart SHALL be an input, 1 bit wide: a one-cycle pulse that starts distribution from IDLE.
REQ-005 Port inStop SHALL be an input, 1 bit wide: a pulse requesting a stop at the next burst boundary.
REQ-006 Port inLaneEn SHALL be an input, 4 bits wide: the per-lane enable mask.
REQ-007 Port inBurstLen SHALL be an input, BURST_W bits wide: the number of bits sent per lane before switching lanes; 0 is treated as 1.
REQ-008 Port inData SHALL be an input, 1 bit wide: the serial source bit.
REQ-009 Port inValid SHALL be an input, 1 bit wide: the source valid signal.
REQ-010 Port outReady SHALL be an output, 1 bit wide: the source ready signal; a beat is accepted when inValid and outReady are both 1.
REQ-011 Port inLaneReady SHALL be an input, 4 bits wide: the per-lane downstream ready.
REQ-012 Port outSel SHALL be an output, 2 bits wide: the select driven to the 1:4 demux inSel.
REQ-013 Port outDemuxData SHALL be an output, 1 bit wide: the registered bit driven to the demux inData.
REQ-014 Port outLaneValid SHALL be an output, 4 bits wide: a one-hot strobe per delivered bit.
REQ-015 Port outBusy SHALL be an output, 1 bit wide: high whenever the FSM is not in IDLE.
REQ-016 Port outBitCnt SHALL be an output, 16 bits wide: the total number of bits delivered since reset.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ARB and XFER.
REQ-018 In IDLE, outReady SHALL be 0; on inStart=1 with inStop=0, the FSM SHALL go to ARB; inStart and inStop together SHALL leave the FSM in IDLE.
REQ-019 ARB SHALL last one cycle; it SHALL select the first enabled lane searching from lastLane+1 upward with wrap 3->0, latch that lane into sel and lastLane, load the burst counter from inBurstLen (0 loads 1), clear the latched stop, and go to XFER.
REQ-020 In ARB with inLaneEn=0, or with a stop already latched, the FSM SHALL go to IDLE and SHALL NOT change sel.
REQ-021 In XFER, outReady SHALL equal inLaneReady[sel] combinationally; with inLaneReady[sel]=0 the FSM SHALL stall indefinitely with no timeout.
REQ-022 On an accepted beat, the next cycle SHALL show outDemuxData=inData, outSel=sel, and outLaneValid = one-hot(sel) for exactly one cycle, giving a latency of 1 cycle; outLaneValid SHALL be 0 in all other cycles.
REQ-023 On each accepted beat, the burst counter SHALL decrement; the beat that takes it from 1 to 0 SHALL end the burst, and the FSM SHALL go to ARB, or to IDLE if a stop is latched.
REQ-024 An inStop pulse in ARB or XFER SHALL be latched and honoured only at the burst boundary; the current burst SHALL always complete.
REQ-025 Changes to inLaneEn or inBurstLen during XFER SHALL NOT affect the current burst; they SHALL be sampled at the next ARB.
REQ-026 A lane disabled mid-burst SHALL still finish its burst.
REQ-027 inStart SHALL be ignored outside IDLE, and inStop SHALL be ignored in IDLE.
REQ-028 outBitCnt SHALL increment by 1 per accepted beat and SHALL wrap from 16'hFFFF to 0.
REQ-029 outSel SHALL hold its last value between beats, so the demux output remains stable.

Reset
REQ-030 While inResetN=0, asynchronously: state=IDLE, lastLane=3 (so the first grant goes to lane 0), sel=0, burst counter=0, stop latch=0, and outSel, outDemuxData, outLaneValid, outReady, outBusy and outBitCnt all 0.
REQ-031 Reset asserted mid-burst SHALL abort the burst immediately with no further outLaneValid pulses; the FSM SHALL restart only on a new inStart after reset release.

Verification
REQ-032 Scenario: inLaneEn=4'b1111, inBurstLen=2, continuous valid, all lanes ready, 8 bits -> lanes 0,0,1,1,2,2,3,3 strobed, each 1 cycle after acceptance, with outBitCnt=8.
REQ-033 Scenario: inLaneEn=4'b1010, inBurstLen=1, 4 bits -> lanes 1,3,1,3, with an ARB gap of 1 cycle between bursts.
REQ-034 Scenario: inBurstLen=4, inLaneReady[0] dropped for 5 cycles after 2 bits -> outReady=0 for those 5 cycles, no strobes, then the remaining 2 bits go to lane 0.
REQ-035 Scenario: inStop pulsed after the 1st bit of a burst with inBurstLen=3 -> 2 more bits are delivered, then outBusy=0 and IDLE; inStart with inStop in the same cycle -> outBusy stays 0.
REQ-036 Scenario: inLaneEn=0 at inStart -> ARB then IDLE, with outReady never 1.
REQ-037 Scenario: reset pulsed mid-burst -> all outputs 0 immediately; after a new inStart, the first grant goes to lane 0.
